// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and the row/column decoder.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } scan_state_t;

   typedef logic [3:0] onehot4_t;

   // Index (0..3) to one-hot active-high vector.
   function automatic onehot4_t idx_to_onehot(input logic [1:0] idx);
      return onehot4_t'(1) << idx;
   endfunction

   // Index of the lowest set bit; bit 0 wins when several are set.
   function automatic logic [1:0] lowest_set(input onehot4_t v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_COLS - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
   parameter int          WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_d;
   logic [WIDTH-1:0] sync_q;

   // Next-state of the two synchronizer stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Two back-to-back flops; reset to the idle (inactive) level.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sampling, press/release
// debounce, and registered one-hot row/column outputs with a press strobe.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic     clk,
   input  logic     reset,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] r,
   output logic [3:0] c,
   output logic     key_valid,
   output logic     key_held
);

   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

   // Synchronized, active-high column view; every decision uses this only.
   logic [3:0] col_sync;
   onehot4_t   col_s;
   logic       col_bit;

   sync_2ff #(
      .WIDTH     (4),
      .RESET_VAL (4'b1111)
   ) u_col_sync (
      .clk   (clk),
      .reset (reset),
      .d     (col_n),
      .q     (col_sync)
   );

   assign col_s = ~col_sync;

   scan_state_t        state_q,     state_d;
   logic [1:0]         row_idx_q,   row_idx_d;
   logic [1:0]         col_idx_q,   col_idx_d;
   logic [DWELL_W-1:0] dwell_q,     dwell_d;
   logic [DB_W-1:0]    db_cnt_q,    db_cnt_d;
   logic [3:0]         row_n_q,     row_n_d;
   onehot4_t           r_q,         r_d;
   onehot4_t           c_q,         c_d;
   logic               key_valid_q, key_valid_d;
   logic               key_held_q,  key_held_d;

   logic [1:0] next_row;

   assign next_row = row_idx_q + 2'd1;
   assign col_bit  = col_s[col_idx_q];

   // Scan/debounce state machine: next-state and registered-output values.
   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      col_idx_d   = col_idx_q;
      dwell_d     = dwell_q;
      db_cnt_d    = db_cnt_q;
      row_n_d     = row_n_q;
      r_d         = r_q;
      c_d         = c_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      case (state_q)
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               // Sample only at the end of the dwell so the synchronizer
               // has settled on this row's columns.
               dwell_d = '0;
               if (|col_s) begin
                  col_idx_d = lowest_set(col_s);
                  db_cnt_d  = '0;
                  state_d   = PRESS_DB;
               end else begin
                  row_idx_d = next_row;
                  row_n_d   = ~idx_to_onehot(next_row);
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end

         PRESS_DB: begin
            if (col_bit) begin
               if (db_cnt_q == DB_LAST) begin
                  state_d     = HELD;
                  db_cnt_d    = '0;
                  r_d         = idx_to_onehot(row_idx_q);
                  c_d         = idx_to_onehot(col_idx_q);
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
               end else begin
                  db_cnt_d = db_cnt_q + 1'b1;
               end
            end else begin
               // Bounce: abandon this candidate and move on to the next row.
               state_d   = SCAN;
               db_cnt_d  = '0;
               dwell_d   = '0;
               row_idx_d = next_row;
               row_n_d   = ~idx_to_onehot(next_row);
            end
         end

         HELD: begin
            // Other columns are ignored; only the latched key matters.
            if (!col_bit) begin
               state_d  = RELEASE_DB;
               db_cnt_d = '0;
            end
         end

         RELEASE_DB: begin
            if (col_bit) begin
               state_d  = HELD;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d    = SCAN;
               db_cnt_d   = '0;
               dwell_d    = '0;
               row_idx_d  = next_row;
               row_n_d    = ~idx_to_onehot(next_row);
               r_d        = '0;
               c_d        = '0;
               key_held_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase
   end

   // State, counters and all outputs registered; reset returns to row 0 scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         row_idx_q   <= 2'd0;
         col_idx_q   <= 2'd0;
         dwell_q     <= '0;
         db_cnt_q    <= '0;
         row_n_q     <= 4'b1110;
         r_q         <= '0;
         c_q         <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_idx_q   <= row_idx_d;
         col_idx_q   <= col_idx_d;
         dwell_q     <= dwell_d;
         db_cnt_q    <= db_cnt_d;
         row_n_q     <= row_n_d;
         r_q         <= r_d;
         c_q         <= c_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign row_n     = row_n_q;
   assign r         = r_q;
   assign c         = c_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random
// single-key presses against a keypad/timing model.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 8;
   // Raw release to key_held falling: 2 synchronizer stages, 1 cycle to see
   // the low sample in HELD, then DB consecutive low samples.
   localparam int REL_LAT  = DB + 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] r;
   logic [3:0] c;
   logic       key_valid;
   logic       key_held;

   // Keys currently pressed, bit index = row*4 + col.
   logic [15:0] key_mask = 16'h0;

   int checks = 0;
   int errors = 0;
   logic prev_kv = 1'b0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .col_n     (col_n),
      .row_n     (row_n),
      .r         (r),
      .c         (c),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Passive matrix: a pressed key pulls its column low while its row is driven low.
   function automatic logic [3:0] keypad(input logic [3:0] rows_n, input logic [15:0] mask);
      logic [3:0] cols;
      cols = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (!rows_n[i]) begin
            cols = cols & ~mask[i*4 +: 4];
         end
      end
      return cols;
   endfunction

   assign col_n = keypad(row_n, key_mask);

   // Decoder model: row/column one-hot pair to hex key code, -1 if not one-hot.
   function automatic int rc_to_hex(input logic [3:0] rv, input logic [3:0] cv);
      int ri;
      int ci;
      ri = -1;
      ci = -1;
      for (int i = 0; i < 4; i++) begin
         if (rv == (4'b0001 << i)) ri = i;
         if (cv == (4'b0001 << i)) ci = i;
      end
      if (ri < 0 || ci < 0) return -1;
      return ri * 4 + ci;
   endfunction

   function automatic int oh(input int idx);
      return 1 << idx;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, then the per-cycle invariants.
   task automatic tick();
      int nz;
      @(posedge clk);
      #1;
      nz = $countones(~row_n);
      chk("row_n_one_low", nz, 1);
      chk("kv_not_back_to_back", int'(prev_kv & key_valid), 0);
      chk("held_matches_r", int'(key_held), int'(r != 4'b0));
      chk("r_c_zero_together", int'(r == 4'b0), int'(c == 4'b0));
      prev_kv = key_valid;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic wait_strobe(output int lat, output bit seen);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         lat++;
         if (key_valid) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Hold for 'hold' cycles checking frozen outputs, then release every key
   // and check the release-debounce latency.
   task automatic hold_and_release(input int hold, input int er, input int ec);
      int n;
      bit fell;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_kv_low", int'(key_valid), 0);
         chk("hold_held", int'(key_held), 1);
         chk("hold_r", int'(r), er);
         chk("hold_c", int'(c), ec);
      end
      key_mask = 16'h0;
      n = 0;
      fell = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         n++;
         chk("release_kv_low", int'(key_valid), 0);
         if (!key_held) begin
            fell = 1'b1;
            break;
         end
      end
      chk("release_seen", int'(fell), 1);
      chk("release_latency", n, REL_LAT);
      chk("release_r_clear", int'(r), 0);
      chk("release_c_clear", int'(c), 0);
   endtask

   initial begin
      int  lat;
      bit  seen;
      int  kr;
      int  kc;
      bit  kv_seen;
      bit  moved;
      bit  held_drop;

      // Reset state and idle scan order.
      do_reset();
      chk("reset_row_n", int'(row_n), 'hE);
      chk("reset_r", int'(r), 0);
      chk("reset_c", int'(c), 0);
      chk("reset_kv", int'(key_valid), 0);
      chk("reset_held", int'(key_held), 0);
      for (int k = 0; k < 40; k++) begin
         if (k > 0) tick();
         chk("idle_row_n", int'(row_n), int'(~4'(oh((k / SCAN_DIV) % 4))) & 'hF);
         chk("idle_kv", int'(key_valid), 0);
         chk("idle_r", int'(r), 0);
         chk("idle_c", int'(c), 0);
      end
      $display("txn idle scan: 40 cycles done");

      // Row1/col2 press with exact strobe latency from reset.
      do_reset();
      key_mask[1*4 + 2] = 1'b1;
      wait_strobe(lat, seen);
      chk("r1c2_strobe_seen", int'(seen), 1);
      chk("r1c2_latency", lat, 1 * SCAN_DIV + SCAN_DIV + DB);
      chk("r1c2_r", int'(r), 'h2);
      chk("r1c2_c", int'(c), 'h4);
      chk("r1c2_hex", rc_to_hex(r, c), 6);
      hold_and_release(30, 'h2, 'h4);
      $display("txn press r1c2: latency=%0d hex=6", lat);

      // Bounce on row2/col0: short press, no strobe, scan resumes at row 3.
      do_reset();
      key_mask[2*4 + 0] = 1'b1;
      kv_seen = 1'b0;
      moved = 1'b0;
      for (int i = 0; i < 40 && row_n != 4'b1011; i++) tick();
      chk("bounce_row2_reached", int'(row_n), 'hB);
      for (int i = 0; i < SCAN_DIV + 3; i++) begin
         tick();
         if (key_valid) kv_seen = 1'b1;
      end
      key_mask = 16'h0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (key_valid) kv_seen = 1'b1;
         if (row_n != 4'b1011) begin
            moved = 1'b1;
            break;
         end
      end
      chk("bounce_moved", int'(moved), 1);
      chk("bounce_next_row3", int'(row_n), 'h7);
      chk("bounce_no_strobe", int'(kv_seen), 0);
      chk("bounce_held", int'(key_held), 0);
      $display("txn bounce r2c0: no strobe, row_n=%b", row_n);

      // Two keys on row 0: second key ignored, then new scan on row 1.
      do_reset();
      key_mask[0] = 1'b1;
      wait_strobe(lat, seen);
      chk("two_strobe_seen", int'(seen), 1);
      chk("two_latency", lat, SCAN_DIV + DB);
      chk("two_r", int'(r), 'h1);
      chk("two_c", int'(c), 'h1);
      key_mask[1] = 1'b1;
      hold_and_release(20, 'h1, 'h1);
      chk("two_rescan_row1", int'(row_n), 'hD);
      $display("txn two keys r0c0+r0c1: single strobe");

      // Column priority: row3 with col1 and col3 together picks col1.
      do_reset();
      key_mask[3*4 + 1] = 1'b1;
      key_mask[3*4 + 3] = 1'b1;
      wait_strobe(lat, seen);
      chk("prio_strobe_seen", int'(seen), 1);
      chk("prio_latency", lat, 3 * SCAN_DIV + SCAN_DIV + DB);
      chk("prio_r", int'(r), 'h8);
      chk("prio_c", int'(c), 'h2);
      hold_and_release(5, 'h8, 'h2);
      $display("txn priority r3 c1+c3: c=%b", 4'h2);

      // Release glitch: re-contact during release debounce returns to HELD.
      do_reset();
      key_mask[2*4 + 3] = 1'b1;
      wait_strobe(lat, seen);
      chk("glitch_strobe_seen", int'(seen), 1);
      repeat (5) tick();
      key_mask = 16'h0;
      repeat (5) tick();
      key_mask[2*4 + 3] = 1'b1;
      repeat (2) tick();
      key_mask = 16'h0;
      kv_seen = 1'b0;
      held_drop = 1'b0;
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         lat++;
         if (key_valid) kv_seen = 1'b1;
         if (!key_held) begin
            held_drop = 1'b1;
            break;
         end
      end
      chk("glitch_no_second_strobe", int'(kv_seen), 0);
      chk("glitch_held_fell", int'(held_drop), 1);
      chk("glitch_release_latency", lat, REL_LAT);
      $display("txn release glitch r2c3: held fell after %0d", lat);

      // Reset while HELD.
      do_reset();
      key_mask[1*4 + 1] = 1'b1;
      wait_strobe(lat, seen);
      chk("rst_held_strobe_seen", int'(seen), 1);
      repeat (3) tick();
      chk("rst_held_before", int'(key_held), 1);
      reset = 1'b1;
      tick();
      chk("rst_held_row_n", int'(row_n), 'hE);
      chk("rst_held_r", int'(r), 0);
      chk("rst_held_c", int'(c), 0);
      chk("rst_held_held", int'(key_held), 0);
      chk("rst_held_kv", int'(key_valid), 0);
      key_mask = 16'h0;
      reset = 1'b0;
      $display("txn reset in HELD: outputs cleared");

      // Random single-key presses with random hold times.
      for (int t = 0; t < 12; t++) begin
         int hold;
         kr = int'($urandom_range(0, 3));
         kc = int'($urandom_range(0, 3));
         hold = int'($urandom_range(1, 20));
         key_mask = 16'h0;
         key_mask[kr*4 + kc] = 1'b1;
         wait_strobe(lat, seen);
         chk("rand_strobe_seen", int'(seen), 1);
         chk("rand_r", int'(r), oh(kr));
         chk("rand_c", int'(c), oh(kc));
         chk("rand_hex", rc_to_hex(r, c), kr * 4 + kc);
         hold_and_release(hold, oh(kr), oh(kc));
         $display("txn random %0d: key r%0d c%0d hex=%0h hold=%0d latency=%0d",
                  t, kr, kc, kr * 4 + kc, hold, lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
